pipe_skid_reg: RTL and testbench
================================

// Module: pipe_skid_reg
// PURPOSE
//  Elastic pipeline register with a valid/ready handshake on both sides. A 2-entry skid buffer.
//  Decouples a producer stage (in_*) from a consumer stage (out_*) in the core datapath.
//  All outputs are registered, so there is no combinational path in_valid->out_valid or out_ready->in_ready.
//  Sustains 1 transfer/cycle and absorbs one cycle of consumer back-pressure without data loss.
// PARAMETERS
//  DATA_W      20  payload width in bits
//  PRESET_VAL  0   value loaded into both data registers and driven on out_data at reset
// PORTS
//  clk        in   1       clock, rising edge
//  arst_n     in   1       asynchronous reset, active-low
//  flush      in   1       synchronous flush: discard all buffered entries
//  in_valid   in   1       producer presents in_data
//  in_ready   out  1       buffer can accept this cycle (registered)
//  in_data    in   DATA_W  payload from producer
//  out_valid  out  1       out_data holds a valid entry (registered)
//  out_ready  in   1       consumer accepts out_data this cycle
//  out_data   out  DATA_W  payload to consumer; always the main register
// BEHAVIOUR
//  - Handshake rules
//    - Input transfer: in_valid & in_ready at a rising edge.
//    - Output transfer: out_valid & out_ready at a rising edge.
//    - in_valid may be asserted regardless of in_ready. Data is only taken when in_ready=1.
//    - out_data and out_valid are stable while out_valid=1 and out_ready=0.
//  - State: 2-bit FSM with states EMPTY, ONE and TWO. Storage is main_q (head) and skid_q (second entry).
//  - Output decode from state only
//    - out_valid = (state != EMPTY)
//    - in_ready  = (state != TWO)
//  - Reset (arst_n=0, asynchronous)
//    - state = EMPTY, main_q = skid_q = PRESET_VAL.
//    - Therefore out_valid=0, in_ready=1 and out_data=PRESET_VAL.
//  - Transitions, when flush=0
//    - EMPTY: in_valid -> ONE, main_q <= in_data. Otherwise stay in EMPTY.
//    - ONE: in_valid & out_ready -> stay in ONE, main_q <= in_data (pass-through).
//    - ONE: in_valid & !out_ready -> TWO, skid_q <= in_data.
//    - ONE: !in_valid & out_ready -> EMPTY.
//    - ONE: otherwise hold.
//    - TWO: out_ready -> ONE, main_q <= skid_q. in_valid is ignored because in_ready=0.
//    - TWO: !out_ready -> hold.
//  - Latency: 1 cycle from the input transfer to out_valid=1 when empty. Data order is strictly FIFO.
//  - Flush
//    - flush=1 at a clock edge forces state=EMPTY.
//    - It has priority over any simultaneous input or output transfer. The input in that cycle is dropped.
//    - main_q and skid_q keep their values. out_data is don't-care while out_valid=0.
//  - Reset mid-operation: buffered entries are lost. There is no partial transfer; outputs immediately take their reset values.
//  - Data registers are written only on the listed transitions. No other writes occur.
// STRUCTURE
//  - Shared package: state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
//    Encoding 2'd3 is illegal; the FSM recovers to EMPTY on the next edge.
//  - One sub-module, skid_ctrl: the FSM.
//    - Outputs: load_main, sel_skid, load_skid, in_ready, out_valid.
//    - Data muxes and the main_q/skid_q registers stay in the top level.
// TESTING
//  1. Reset: arst_n low mid-cycle -> out_valid=0, in_ready=1, out_data=PRESET_VAL immediately, without waiting for clk.
//  2. Streaming: in_valid=1 with values 1,2,3,...,10 and out_ready=1 constantly.
//     -> out_data sequence 1..10, one per cycle, starting 1 cycle after the first input; in_ready never drops.
//  3. Back-pressure: load 0xA then 0xB with out_ready=0.
//     -> in_ready=0 after the 2nd transfer; 0xC is held off.
//     Then release out_ready -> outputs 0xA, 0xB, 0xC in order, no loss or duplicate.
//  4. Stall stability: out_valid=1, out_ready=0 for 5 cycles while in_data toggles -> out_data is unchanged all 5 cycles.
//  5. Flush in TWO with in_valid=1 and out_ready=1 on the same edge.
//     -> next cycle out_valid=0, in_ready=1; no stale entry is emitted afterwards.
//  6. Random: random in_valid/out_ready (50%) over 10k cycles, checked against a reference queue model.
//     -> order preserved, zero loss; assertions hold that out_data is stable under stall.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// rtl/pipe_skid_reg_pkg.sv - shared state encoding and decode helpers for the skid buffer
//
// Purpose:
//   State encoding for the 2-entry skid buffer FSM.
//   Decode helpers for the handshake flags that are derived from the state.
// Contents:
//   skid_state_e       ST_EMPTY=0, ST_ONE=1, ST_TWO=2 (2'd3 is illegal)
//   state_out_valid()  1 when the buffer holds at least one entry
//   state_in_ready()   1 when the buffer can take another entry
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  function automatic logic state_out_valid(input skid_state_e s);
    return (s != ST_EMPTY);
  endfunction

  function automatic logic state_in_ready(input skid_state_e s);
    return (s != ST_TWO);
  endfunction

endpackage

// File: rtl/pipe_skid_reg_skid_ctrl.sv
// rtl/pipe_skid_reg_skid_ctrl.sv - occupancy FSM and register-load strobes for the skid buffer
//
// Purpose:
//   Tracks how many entries (0, 1 or 2) the skid buffer holds and tells the
//   datapath which data register to load on each edge.
// Ports:
//   clk        in   clock, rising edge
//   arst_n     in   asynchronous reset, active-low
//   flush      in   synchronous flush, overrides every transfer
//   in_valid   in   producer offers an entry
//   out_ready  in   consumer takes the head entry
//   load_main  out  load main_q this edge (combinational strobe)
//   sel_skid   out  main_q source: 1 = skid_q, 0 = in_data
//   load_skid  out  load skid_q from in_data this edge
//   in_ready   out  registered, decoded from state
//   out_valid  out  registered, decoded from state
module skid_ctrl
  import pipe_skid_reg_pkg::*;
(
  input  logic clk,
  input  logic arst_n,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  output logic load_main,
  output logic sel_skid,
  output logic load_skid,
  output logic in_ready,
  output logic out_valid
);

  skid_state_e state_q, state_d;
  logic        in_ready_q, out_valid_q;

  // In TWO, in_valid is ignored: in_ready is low, so no input transfer can occur.
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    sel_skid  = 1'b0;
    load_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            state_d   = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_valid && out_ready) begin
            load_main = 1'b1;
          end else if (in_valid) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (out_ready) begin
            state_d   = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            state_d   = ST_ONE;
            load_main = 1'b1;
            sel_skid  = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Flags are decoded from the next state and registered, so neither
  // in_ready nor out_valid has a combinational path from the inputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= state_out_valid(state_d);
      in_ready_q  <= state_in_ready(state_d);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - elastic 2-entry skid pipeline register with valid/ready on both sides
//
// Purpose:
//   Decouples a producer stage from a consumer stage. Sustains one transfer per
//   cycle and absorbs one cycle of consumer back-pressure without loss. All
//   outputs are registered.
// Parameters:
//   DATA_W      payload width
//   PRESET_VAL  reset value of both data registers (seen on out_data after reset)
// Ports:
//   clk        in   clock, rising edge
//   arst_n     in   asynchronous reset, active-low
//   flush      in   discard all buffered entries at the next edge
//   in_valid   in   producer presents in_data
//   in_ready   out  buffer can accept this cycle
//   in_data    in   payload from producer
//   out_valid  out  out_data holds a valid entry
//   out_ready  in   consumer accepts out_data this cycle
//   out_data   out  payload to consumer, always main_q
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned        DATA_W     = 20,
  parameter logic [DATA_W-1:0]  PRESET_VAL = '0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              load_main, sel_skid, load_skid;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  skid_ctrl u_ctrl (
    .clk       (clk),
    .arst_n    (arst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .load_main (load_main),
    .sel_skid  (sel_skid),
    .load_skid (load_skid),
    .in_ready  (in_ready),
    .out_valid (out_valid)
  );

  // main_q is the head; on a pop from TWO it takes the second entry from skid_q.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (load_main) begin
      main_d = sel_skid ? skid_q : in_data;
    end
    if (load_skid) begin
      skid_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      main_q <= PRESET_VAL;
      skid_q <= PRESET_VAL;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out_data = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - self-checking bench for pipe_skid_reg
module tb_pipe_skid_reg;

  localparam int W = 20;
  localparam logic [W-1:0] PRESET = 20'h5A5A5;

  logic         clk       = 1'b0;
  logic         arst_n    = 1'b1;
  logic         flush     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data   = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         iv;
    logic         ordy;
    logic         fl;
    logic [W-1:0] d;
    logic         exp_ov;
    logic         exp_ir;
    logic [W-1:0] exp_od;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] q[$];

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(W), .PRESET_VAL(PRESET)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assert property (@(posedge clk) disable iff (!arst_n)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)))
    else $error("out_data/out_valid changed while stalled");

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic ordy, input logic fl, input logic [W-1:0] d,
                     input logic ov, input logic ir, input logic [W-1:0] od);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.d = d;
    v.exp_ov = ov; v.exp_ir = ir; v.exp_od = od;
    vecs.push_back(v);
  endtask

  initial begin
    // Streaming 1..10: each output appears one cycle after its input.
    for (int i = 1; i <= 10; i++) add(1, 1, 0, W'(i), 1, 1, W'(i));
    add(0, 1, 0, 20'h0, 0, 1, 20'd10);
    // Back-pressure: A, B fill the buffer, C is held off, then drain in order.
    add(1, 0, 0, 20'hA, 1, 1, 20'hA);
    add(1, 0, 0, 20'hB, 1, 0, 20'hA);
    add(1, 0, 0, 20'hC, 1, 0, 20'hA);
    add(1, 1, 0, 20'hC, 1, 1, 20'hB);
    add(1, 1, 0, 20'hC, 1, 1, 20'hC);
    add(0, 1, 0, 20'h0, 0, 1, 20'hC);
    // Stall stability in TWO with toggling in_data.
    add(1, 0, 0, 20'h11, 1, 1, 20'h11);
    add(1, 0, 0, 20'h22, 1, 0, 20'h11);
    for (int i = 0; i < 5; i++) add(1, 0, 0, (i % 2 == 0) ? 20'hFFFFF : 20'h00000, 1, 0, 20'h11);
    // Flush in TWO with simultaneous input and output transfer attempts.
    add(1, 1, 1, 20'h33, 0, 1, 20'h11);
    add(0, 1, 0, 20'h0, 0, 1, 20'h11);
    add(0, 0, 0, 20'h0, 0, 1, 20'h11);
    // ONE hold, then drain to EMPTY.
    add(1, 0, 0, 20'h44, 1, 1, 20'h44);
    add(0, 0, 0, 20'h0, 1, 1, 20'h44);
    add(0, 1, 0, 20'h0, 0, 1, 20'h44);
    // Flush from ONE drops the concurrent input.
    add(1, 0, 0, 20'h55, 1, 1, 20'h55);
    add(1, 0, 1, 20'h66, 0, 1, 20'h55);
    add(1, 0, 0, 20'h77, 1, 1, 20'h77);

    // Reset asserted with no clock edge in between.
    #2 arst_n = 1'b0;
    #2;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_data", 32'(out_data), 32'(PRESET));
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      in_data   = vecs[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
      chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
    end
    flush = 1'b0;

    // Fill to TWO, then reset mid-cycle: outputs must change before any clock edge.
    in_valid  = 1'b1;
    in_data   = 20'h88;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("pre-reset in_ready", 32'(in_ready), 32'd0);
    #3 arst_n = 1'b0;
    #1;
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset in_ready", 32'(in_ready), 32'd1);
    chk("midreset out_data", 32'(out_data), 32'(PRESET));
    in_valid = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset out_valid", 32'(out_valid), 32'd0);
    chk("post-reset out_data", 32'(out_data), 32'(PRESET));

    // Random traffic against a queue model of at most two entries.
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      int sz;
      flush     = ($urandom_range(0, 31) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = W'($urandom);
      sz = q.size();
      if (flush) begin
        q.delete();
      end else begin
        if (out_ready && sz > 0) void'(q.pop_front());
        if (in_valid && sz < 2) q.push_back(in_data);
      end
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d out_valid", c), 32'(out_valid), 32'(q.size() != 0));
      chk($sformatf("rnd%0d in_ready", c), 32'(in_ready), 32'(q.size() < 2));
      if (q.size() != 0) chk($sformatf("rnd%0d out_data", c), 32'(out_data), 32'(q[0]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
